// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier with a parameterised operand width.
// Operands are signed (two's complement) or unsigned, chosen per operation.
// The design multiplies the operand magnitudes and then applies the result
// sign once at the end. It retires one multiplier bit per clock, LSB first.
// A result is ready exactly WIDTH cycles after the edge that samples start.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] o,
  output logic               busy,
  output logic               finish
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;     // multiplicand magnitude
  logic [WIDTH-1:0]   mplier;    // multiplier magnitude, shifted right each cycle
  logic               neg;       // result sign, applied after the last step
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;

  // The most-negative operand negates to 2^(WIDTH-1). That value still fits
  // as an unsigned WIDTH-bit magnitude.
  assign mag_a = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign mag_b = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // Partial product for the current multiplier bit, and the next accumulator value
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
    addend = '0;
    if (mplier[0]) begin
      addend = {{WIDTH{1'b0}}, mcand} << count;
    end
    acc_next = acc + addend;
  end

  // Control FSM and datapath registers. All outputs are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      count  <= '0;
      o      <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == LAST) begin
            // Negating a zero magnitude gives zero, so a negative zero cannot occur.
            o      <= neg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
            busy   <= 1'b0;
            finish <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Wait here until start drops. A start held high cannot retrigger.
          if (!start) begin
            finish <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          finish <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Testbench for seq_mult_param. The driver pushes the expected product and
// the issue cycle into a scoreboard queue. A monitor pops an entry on every
// rising edge of finish, then compares the product and the latency.
module tb_seq_mult_param;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [PW-1:0]   o;
  logic            busy;
  logic            finish;

  typedef struct {
    logic [PW-1:0] prod;
    int            issue_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic fin_q  = 1'b0;

  seq_mult_param #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .o           (o),
    .busy        (busy),
    .finish      (finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: interpret the operands as integers and multiply them. The
  // result is the low 2*WIDTH bits of the true product.
  function automatic logic [PW-1:0] model(input logic sm, input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y);
    longint sx;
    longint sy;
    sx = longint'(x);
    sy = longint'(y);
    if (sm && x[WIDTH-1]) sx = sx - (longint'(1) << WIDTH);
    if (sm && y[WIDTH-1]) sy = sy - (longint'(1) << WIDTH);
    return PW'(sx * sy);
  endfunction

  // Monitor: each rising edge of finish must match the oldest outstanding request
  always @(negedge clk) begin
    if (!reset_n) begin
      fin_q = 1'b0;
    end else begin
      if (finish && !fin_q) begin
        if (sb_q.size() == 0) begin
          check("unexpected_finish", 64'(finish), 64'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("product", 64'(o), 64'(e.prod));
          check("latency", 64'(cyc - e.issue_cyc), 64'(WIDTH));
        end
      end
      fin_q = finish;
    end
  end

  // Run one full handshake. The driver holds start for `extra` cycles after
  // finish, then releases it. Optionally it perturbs the inputs mid-operation.
  task automatic run_op(input logic sm, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input int extra, input bit change_mid);
    logic [PW-1:0] exp_o;
    exp_t          e;
    bit            seen;
    exp_o = model(sm, va, vb);
    @(negedge clk);
    start       = 1'b1;
    signed_mode = sm;
    a           = va;
    b           = vb;
    e.prod      = exp_o;
    e.issue_cyc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check("busy_after_start", 64'(busy), 64'(1));
    if (change_mid) begin
      repeat (2) @(posedge clk);
      #1;
      a           = WIDTH'(3);
      b           = WIDTH'(3);
      signed_mode = 1'b1;
    end
    seen = 1'b0;
    for (int t = 0; t < 4 * WIDTH + 8 && !seen; t++) begin
      @(negedge clk);
      if (finish) seen = 1'b1;
    end
    if (!seen) begin
      check("finish_timeout", 64'(finish), 64'(1));
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    check("busy_at_finish", 64'(busy), 64'(0));
    for (int k = 0; k < extra; k++) begin
      @(negedge clk);
      check("hold_finish", 64'(finish), 64'(1));
      check("hold_busy", 64'(busy), 64'(0));
      check("hold_o", 64'(o), 64'(exp_o));
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check("finish_drop", 64'(finish), 64'(0));
    check("o_retained", 64'(o), 64'(exp_o));
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] all1;
    mn   = WIDTH'(1) << (WIDTH - 1);
    mx   = mn - WIDTH'(1);
    all1 = '1;

    reset_n     = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_o", 64'(o), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_finish", 64'(finish), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases and corner cases
    run_op(1'b0, WIDTH'(200), WIDTH'(150), 0, 1'b0);
    run_op(1'b1, mn, mn, 1, 1'b0);
    run_op(1'b1, mn, mx, 0, 1'b0);
    run_op(1'b1, all1, WIDTH'(1), 0, 1'b0);
    run_op(1'b1, WIDTH'(0), WIDTH'(-5), 0, 1'b0);
    run_op(1'b0, all1, all1, 2, 1'b0);
    run_op(1'b0, WIDTH'(12), WIDTH'(11), 0, 1'b1);

    // Assert reset part-way through BUSY. The clear must take effect without a clock edge.
    @(negedge clk);
    start       = 1'b1;
    signed_mode = 1'b0;
    a           = WIDTH'(13);
    b           = WIDTH'(7);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_o", 64'(o), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_finish", 64'(finish), 64'(0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_abort_finish", 64'(finish), 64'(0));
    check("post_abort_o", 64'(o), 64'(0));
    run_op(1'b0, WIDTH'(7), WIDTH'(9), 0, 1'b0);

    // Random operations. The first of each batch holds start for five extra cycles.
    for (int i = 0; i < 30; i++) begin
      run_op(1'b0, WIDTH'($urandom), WIDTH'($urandom), (i == 0) ? 5 : int'($urandom_range(0, 2)), 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      run_op(1'b1, WIDTH'($urandom), WIDTH'($urandom), (i == 0) ? 5 : int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
